video_dram_arb: RTL and testbench

- DRAM-side responder for the video subsystem's memory requesters: the bitmap fetcher (video_go/video_bw), the tile-map reader (tm_req) and the TS renderer (ts_req). The Z80 is a fourth requester.
- Slices DRAM time into 4-clk cycles and grants each cycle to exactly one requester or none.
- Drives the DRAM controller address/request and returns next/strobe handshakes to the requesters.
- Sits between the video top level and the DRAM controller.

---
 rtl/video_dram_arb.sv | 135 +++++++++++++
 tb/tb_video_dram_arb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/video_dram_arb.sv
// Slices DRAM time into 4-clk cycles and grants each cycle to video, tile-map, TS or Z80.
// Latency: grant decided at cyc2 one cycle ahead, data valid at cyc3 of the access; no backpressure, requests are levels.
module video_dram_arb #(
  parameter int AW = 21
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic [AW-1:0] video_addr,
  input  logic [4:0]    video_bw,
  input  logic          video_go,
  input  logic [AW-1:0] tm_addr,
  input  logic          tm_req,
  input  logic [AW-1:0] ts_addr,
  input  logic          ts_req,
  input  logic          ts_z80_lp,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_req,
  output logic          video_pre_next,
  output logic          ts_pre_next,
  output logic          tm_pre_next,
  output logic          cpu_pre_next,
  output logic          video_next,
  output logic          ts_next,
  output logic          tm_next,
  output logic          cpu_next,
  output logic          video_strobe,
  output logic          next_video,
  output logic [AW-1:0] dram_addr,
  output logic          dram_req,
  output logic [1:0]    cyc
);

  localparam logic [2:0] OWN_IDLE  = 3'd0;
  localparam logic [2:0] OWN_VIDEO = 3'd1;
  localparam logic [2:0] OWN_TM    = 3'd2;
  localparam logic [2:0] OWN_TS    = 3'd3;
  localparam logic [2:0] OWN_CPU   = 3'd4;

  logic [4:0]    slot;
  logic [4:0]    last_slot;
  logic [4:0]    next_slot;
  logic [1:0]    win_w;
  logic [3:0]    win_n;
  logic [3:0]    bw_n;
  logic [3:0]    new_n;
  logic          video_slot;
  logic [2:0]    winner;
  logic [AW-1:0] winner_addr;
  logic [2:0]    pend_own;
  logic [AW-1:0] pend_addr;
  logic [2:0]    owner;

  always_comb begin
    last_slot = 5'd3;
    case (win_w)
      2'd0:    last_slot = 5'd3;
      2'd1:    last_slot = 5'd7;
      2'd2:    last_slot = 5'd15;
      default: last_slot = 5'd31;
    endcase
  end

  assign next_slot = (slot == last_slot) ? 5'd0 : slot + 5'd1;

  // Only the 4-slot window can be shorter than the requested video slot count.
  assign bw_n  = {1'b0, video_bw[2:0]} + 4'd1;
  assign new_n = (video_bw[4:3] == 2'd0 && bw_n > 4'd4) ? 4'd4 : bw_n;

  // Slot 0 of a window is always below N, so the stale N at a window boundary is harmless.
  assign video_slot = video_go && (next_slot < {1'b0, win_n});

  always_comb begin
    winner      = OWN_IDLE;
    winner_addr = video_addr;
    if (video_slot) begin
      winner      = OWN_VIDEO;
      winner_addr = video_addr;
    end else if (tm_req) begin
      winner      = OWN_TM;
      winner_addr = tm_addr;
    end else if (ts_z80_lp && cpu_req) begin
      winner      = OWN_CPU;
      winner_addr = cpu_addr;
    end else if (ts_req) begin
      winner      = OWN_TS;
      winner_addr = ts_addr;
    end else if (cpu_req) begin
      winner      = OWN_CPU;
      winner_addr = cpu_addr;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cyc       <= 2'd0;
      slot      <= 5'd0;
      win_w     <= 2'd0;
      win_n     <= 4'd0;
      pend_own  <= OWN_IDLE;
      pend_addr <= '0;
      owner     <= OWN_IDLE;
      dram_addr <= '0;
    end else begin
      cyc <= cyc + 2'd1;
      if (cyc == 2'd0 && slot == 5'd0) begin
        win_w <= video_bw[4:3];
        win_n <= new_n;
      end
      if (cyc == 2'd2) begin
        pend_own  <= winner;
        pend_addr <= winner_addr;
      end
      if (cyc == 2'd3) begin
        slot  <= next_slot;
        owner <= pend_own;
        if (pend_own != OWN_IDLE) dram_addr <= pend_addr;
      end
    end
  end

  assign dram_req   = (owner != OWN_IDLE);
  assign next_video = (owner == OWN_VIDEO);

  assign video_pre_next = (cyc == 2'd2) && (winner == OWN_VIDEO);
  assign tm_pre_next    = (cyc == 2'd2) && (winner == OWN_TM);
  assign ts_pre_next    = (cyc == 2'd2) && (winner == OWN_TS);
  assign cpu_pre_next   = (cyc == 2'd2) && (winner == OWN_CPU);

  assign video_next   = (cyc == 2'd3) && (owner == OWN_VIDEO);
  assign tm_next      = (cyc == 2'd3) && (owner == OWN_TM);
  assign ts_next      = (cyc == 2'd3) && (owner == OWN_TS);
  assign cpu_next     = (cyc == 2'd3) && (owner == OWN_CPU);
  assign video_strobe = video_next;

endmodule

// File: tb/tb_video_dram_arb.sv
// Directed bench for video_dram_arb: owner sequences per DRAM cycle plus a random exclusivity sweep.
module tb_video_dram_arb;
  localparam int AW = 21;

  logic          clk;
  logic          res_n;
  logic [AW-1:0] video_addr;
  logic [4:0]    video_bw;
  logic          video_go;
  logic [AW-1:0] tm_addr;
  logic          tm_req;
  logic [AW-1:0] ts_addr;
  logic          ts_req;
  logic          ts_z80_lp;
  logic [AW-1:0] cpu_addr;
  logic          cpu_req;
  logic          video_pre_next, ts_pre_next, tm_pre_next, cpu_pre_next;
  logic          video_next, ts_next, tm_next, cpu_next;
  logic          video_strobe;
  logic          next_video;
  logic [AW-1:0] dram_addr;
  logic          dram_req;
  logic [1:0]    cyc;

  video_dram_arb #(.AW(AW)) dut (
    .clk(clk), .res_n(res_n),
    .video_addr(video_addr), .video_bw(video_bw), .video_go(video_go),
    .tm_addr(tm_addr), .tm_req(tm_req),
    .ts_addr(ts_addr), .ts_req(ts_req), .ts_z80_lp(ts_z80_lp),
    .cpu_addr(cpu_addr), .cpu_req(cpu_req),
    .video_pre_next(video_pre_next), .ts_pre_next(ts_pre_next),
    .tm_pre_next(tm_pre_next), .cpu_pre_next(cpu_pre_next),
    .video_next(video_next), .ts_next(ts_next), .tm_next(tm_next), .cpu_next(cpu_next),
    .video_strobe(video_strobe), .next_video(next_video),
    .dram_addr(dram_addr), .dram_req(dram_req), .cyc(cyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            lp_at = -1;
  logic [AW-1:0] last_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bit order {video, tm, ts, cpu}; I = idle, V = video, M = tile map, S = TS, C = Z80.
  function automatic logic [3:0] vec_of(input byte c);
    case (c)
      "V":     return 4'b1000;
      "M":     return 4'b0100;
      "S":     return 4'b0010;
      "C":     return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [AW-1:0] addr_of(input byte c);
    case (c)
      "V":     return video_addr;
      "M":     return tm_addr;
      "S":     return ts_addr;
      default: return cpu_addr;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    res_n     = 1'b1;
    last_addr = '0;
  endtask

  // Starts at cyc0 of the first listed cycle; the final character only feeds the last pre_next check.
  task automatic run_seq(input string tag, input string seq);
    byte c, nc;
    for (int k = 0; k < seq.len() - 1; k++) begin
      c  = seq[k];
      nc = seq[k+1];
      if (c != "I") last_addr = addr_of(c);
      chk({tag, "_cyc"}, {30'd0, cyc}, 32'd0);
      chk({tag, "_next_video"}, {31'd0, next_video}, {31'd0, c == "V"});
      chk({tag, "_dram_req"}, {31'd0, dram_req}, {31'd0, c != "I"});
      chk({tag, "_dram_addr"}, {11'd0, dram_addr}, {11'd0, last_addr});
      step();
      if (k == lp_at) ts_z80_lp = 1'b1;
      step();
      chk({tag, "_pre_next"}, {28'd0, video_pre_next, tm_pre_next, ts_pre_next, cpu_pre_next},
          {28'd0, vec_of(nc)});
      step();
      chk({tag, "_next"}, {28'd0, video_next, tm_next, ts_next, cpu_next}, {28'd0, vec_of(c)});
      chk({tag, "_strobe"}, {31'd0, video_strobe}, {31'd0, c == "V"});
      step();
    end
  endtask

  int viol;

  initial begin
    res_n      = 1'b0;
    video_addr = 21'h00100;
    tm_addr    = 21'h0A5A5;
    ts_addr    = 21'h15555;
    cpu_addr   = 21'h1ABCD;
    ts_z80_lp  = 1'b0;

    // L=8, N=3, everyone requesting
    video_bw = 5'b01_010;
    video_go = 1'b1;
    tm_req   = 1'b1;
    ts_req   = 1'b1;
    cpu_req  = 1'b1;
    do_reset();
    run_seq("vid_tm", "IVVMMMMMVVVM");
    tm_req = 1'b0;
    run_seq("vid_ts", "MSSSSVV");

    // Z80 alone
    video_go = 1'b0;
    ts_req   = 1'b0;
    cpu_req  = 1'b1;
    do_reset();
    run_seq("cpu", "ICCCCCC");

    // TS vs Z80 priority flip mid-cycle
    ts_req = 1'b1;
    lp_at  = 2;
    run_seq("lp", "CSSCC");
    lp_at     = -1;
    ts_z80_lp = 1'b0;

    // window reprogrammed at slot 3: N=2 now, N=6 next window
    video_bw = 5'b01_001;
    video_go = 1'b1;
    tm_req   = 1'b1;
    ts_req   = 1'b0;
    cpu_req  = 1'b0;
    do_reset();
    run_seq("win_a", "IVMM");
    video_bw = 5'b01_101;
    run_seq("win_b", "MMMMMVVVVVVMMV");

    // reset in cyc1 of a video access
    step();
    res_n = 1'b0;
    #1;
    chk("rst_cyc", {30'd0, cyc}, 32'd0);
    chk("rst_next_video", {31'd0, next_video}, 32'd0);
    chk("rst_dram_req", {31'd0, dram_req}, 32'd0);
    chk("rst_dram_addr", {11'd0, dram_addr}, 32'd0);
    chk("rst_pre", {28'd0, video_pre_next, tm_pre_next, ts_pre_next, cpu_pre_next}, 32'd0);
    chk("rst_next", {28'd0, video_next, tm_next, ts_next, cpu_next}, 32'd0);
    do_reset();
    run_seq("post_rst", "IVV");

    // nothing requesting
    video_go = 1'b0;
    tm_req   = 1'b0;
    do_reset();
    run_seq("idle", "IIIIII");

    // random sweep: never two grants or two data strobes at once
    viol = 0;
    for (int i = 0; i < 10000; i++) begin
      video_go  = 1'($urandom_range(0, 1));
      video_bw  = 5'($urandom_range(0, 31));
      tm_req    = 1'($urandom_range(0, 1));
      ts_req    = 1'($urandom_range(0, 1));
      cpu_req   = 1'($urandom_range(0, 1));
      ts_z80_lp = 1'($urandom_range(0, 1));
      step();
      if ($countones({video_pre_next, tm_pre_next, ts_pre_next, cpu_pre_next}) > 1) viol++;
      if ($countones({video_next, tm_next, ts_next, cpu_next}) > 1) viol++;
      if (video_strobe !== video_next) viol++;
    end
    chk("onehot_sweep", viol, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
